seg_capture: RTL and testbench



---
 rtl/seg_capture_pkg.sv | 23 ++
 rtl/seg_capture_seg7_to_hex.sv | 22 ++
 rtl/seg_capture.sv | 169 ++++++++++++++++
 tb/tb_seg_capture.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_capture_pkg.sv
// Shared constants and types for the seven-segment receive monitor.
// Segment codes are active-low {g,f,e,d,c,b,a}, indexed by hex value.
package seg_capture_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HELD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] anode;
        logic [7:0] segments;
    } bus_t;

endpackage

// File: rtl/seg_capture_seg7_to_hex.sv
// Combinational seven-segment to hex decoder; valid is low for any pattern
// that is not one of the sixteen hex glyphs.
module seg7_to_hex
    import seg_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] hex
);

    always_comb begin
        valid = 1'b0;
        hex   = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                valid = 1'b1;
                hex   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_capture.sv
// Receive-side monitor for the multiplexed 8-digit seven-segment bus.
// Optional macro SEG_CAPTURE_DP_EN: capture the decimal point and include it
// in the stability compare; otherwise segments[7] is ignored and dp is 0.
module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  segments,
    input  logic [7:0]  anode,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        pattern_err,
    output logic [2:0]  err_sel
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);
`ifdef SEG_CAPTURE_DP_EN
    localparam logic [15:0] CMP_MASK = 16'hFFFF;
`else
    localparam logic [15:0] CMP_MASK = 16'hFF7F;
`endif

    bus_t        s_q, s_d, prev_q, prev_d;
    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  dp_q, dp_d;
    logic [7:0]  valid_q, valid_d;
    logic [7:0]  visited_q, visited_d;
    logic        frame_done_q, frame_done_d;
    logic        pattern_err_q, pattern_err_d;
    logic [2:0]  err_sel_q, err_sel_d;

    logic        slot_ok;
    logic [2:0]  sel;
    logic        changed;
    logic        capture;
    logic        dec_valid;
    logic [3:0]  dec_hex;
    logic [7:0]  visited_nx;

    seg7_to_hex u_dec (
        .seg   (s_q.segments[6:0]),
        .valid (dec_valid),
        .hex   (dec_hex)
    );

    always_comb begin
        slot_ok = $onehot(~s_q.anode);
        sel     = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!s_q.anode[i]) sel = 3'(i);
        end
        changed = (((s_q ^ prev_q) & CMP_MASK) != 16'h0);
    end

    always_comb begin
        s_d     = bus_t'({anode, segments});
        prev_d  = s_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;

        if (!slot_ok) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TRACK;
                    cnt_d   = 8'd1;
                end
                ST_TRACK: begin
                    if (changed) begin
                        cnt_d = 8'd1;
                    end else if (cnt_q >= STABLE_CNT) begin
                        capture = 1'b1;
                        state_d = ST_HELD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_HELD: begin
                    if (changed) begin
                        state_d = ST_TRACK;
                        cnt_d   = 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        digits_d      = digits_q;
        dp_d          = dp_q;
        valid_d       = valid_q;
        visited_d     = visited_q;
        err_sel_d     = err_sel_q;
        frame_done_d  = 1'b0;
        pattern_err_d = 1'b0;
        visited_nx    = visited_q | (8'd1 << sel);

        if (capture) begin
            if (dec_valid) begin
                digits_d[{sel, 2'b00} +: 4] = dec_hex;
                valid_d[sel]                = 1'b1;
`ifdef SEG_CAPTURE_DP_EN
                dp_d[sel]                   = ~s_q.segments[7];
`endif
            end else begin
                valid_d[sel]  = 1'b0;
                pattern_err_d = 1'b1;
                err_sel_d     = sel;
            end
            // A completed frame restarts tracking in the same cycle.
            if (visited_nx == 8'hFF) begin
                frame_done_d = 1'b1;
                visited_d    = 8'h00;
            end else begin
                visited_d    = visited_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q           <= '1;
            prev_q        <= '1;
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            digits_q      <= 32'h0;
            dp_q          <= 8'h0;
            valid_q       <= 8'h0;
            visited_q     <= 8'h0;
            frame_done_q  <= 1'b0;
            pattern_err_q <= 1'b0;
            err_sel_q     <= 3'd0;
        end else begin
            s_q           <= s_d;
            prev_q        <= prev_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            valid_q       <= valid_d;
            visited_q     <= visited_d;
            frame_done_q  <= frame_done_d;
            pattern_err_q <= pattern_err_d;
            err_sel_q     <= err_sel_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_done_q;
    assign pattern_err = pattern_err_q;
    assign err_sel     = err_sel_q;

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: each driven slot pushes its expected
// output snapshot; a per-edge monitor compares against it when due.
module tb_seg_capture;

    localparam int STABLE = 4;

    localparam logic [6:0] LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  segments = 8'hFF;
    logic [7:0]  anode = 8'hFF;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        pattern_err;
    logic [2:0]  err_sel;

    seg_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .segments    (segments),
        .anode       (anode),
        .digits      (digits),
        .dp          (dp),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .pattern_err (pattern_err),
        .err_sel     (err_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [52:0] snap;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_cnt = 0;
    bit          mon_en = 1'b0;
    logic [52:0] last_snap = '0;

    logic [31:0] m_digits;
    logic [7:0]  m_dp, m_valid, m_visited;
    logic [2:0]  m_err_sel;
    logic [15:0] m_prev;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] bus_key(input logic [7:0] an, input logic [7:0] sg);
        logic [15:0] k;
        k = {an, sg};
`ifndef SEG_CAPTURE_DP_EN
        k[7] = 1'b0;
`endif
        return k;
    endfunction

    task automatic model_clear();
        m_digits  = '0;
        m_dp      = '0;
        m_valid   = '0;
        m_visited = '0;
        m_err_sel = '0;
        m_prev    = bus_key(8'hFF, 8'hFF);
        last_snap = '0;
    endtask

    // Drive one bus value for n cycles and predict its capture, if any.
    task automatic hold(input logic [7:0] an, input logic [7:0] sg, input int n);
        exp_t        e;
        int          pos;
        bit          fd, pe, found;
        logic [3:0]  hx;
        logic [15:0] cur;
        @(negedge clk);
        anode    = an;
        segments = sg;
        cur = bus_key(an, sg);
        if ($countones(~an) == 1 && n >= STABLE + 1 && cur != m_prev) begin
            pos = 0;
            for (int i = 0; i < 8; i++) if (!an[i]) pos = i;
            found = 1'b0;
            hx = 4'h0;
            for (int h = 0; h < 16; h++) begin
                if (sg[6:0] == LUT[h]) begin
                    found = 1'b1;
                    hx = h[3:0];
                end
            end
            fd = 1'b0;
            pe = 1'b0;
            m_visited[pos] = 1'b1;
            if (found) begin
                m_digits[pos*4 +: 4] = hx;
                m_valid[pos] = 1'b1;
`ifdef SEG_CAPTURE_DP_EN
                m_dp[pos] = ~sg[7];
`endif
            end else begin
                m_valid[pos] = 1'b0;
                pe = 1'b1;
                m_err_sel = pos[2:0];
            end
            if (m_visited == 8'hFF) begin
                fd = 1'b1;
                m_visited = 8'h00;
            end
            e.due  = edge_cnt + STABLE + 2;
            e.snap = {m_digits, m_dp, m_valid, m_err_sel, fd, pe};
            sb_q.push_back(e);
        end
        m_prev = cur;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] an, input logic [7:0] sg);
        @(negedge clk);
        check_eq("sb_empty_before_reset", 64'(sb_q.size()), 64'd0);
        rst      = 1'b1;
        anode    = an;
        segments = sg;
        mon_en   = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", 64'({digits, dp, digit_valid, err_sel, frame_done, pattern_err}), 64'd0);
        rst      = 1'b0;
        anode    = 8'hFF;
        segments = 8'hFF;
    endtask

    always @(posedge clk) begin
        logic [52:0] exp;
        #1;
        edge_cnt++;
        if (mon_en) begin
            exp = last_snap;
            if (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
                exp = sb_q.pop_front().snap;
                last_snap = {exp[52:2], 2'b00};
            end
            check_eq("outputs", 64'({digits, dp, digit_valid, err_sel, frame_done, pattern_err}), 64'(exp));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        do_reset(8'h5A, 8'h3C);

        hold(8'hFE, 8'hC0, 6);
        hold(8'hFF, 8'hFF, 2);

        for (int i = 0; i < 8; i++)
            hold(~(8'd1 << i), {(i == 3) ? 1'b0 : 1'b1, LUT[i+1]}, 8);
        hold(8'hFF, 8'hFF, 2);

        hold(8'hFB, 8'hF9, 4);
        hold(8'hFF, 8'hFF, 2);

        hold(8'hFB, 8'hF9, 2);
        hold(8'hFB, 8'h80, 1);
        hold(8'hFB, 8'hF9, 5);
        hold(8'hFF, 8'hFF, 2);

        hold(8'hDF, 8'hFF, 8);
        hold(8'hFF, 8'hFF, 2);

        hold(8'hFC, 8'hF9, 20);
        hold(8'hFF, 8'hA4, 20);

        for (int i = 0; i < 4; i++)
            hold(~(8'd1 << i), {1'b1, LUT[9+i]}, 8);
        hold(8'hFF, 8'hFF, 2);
        do_reset(8'h00, 8'h00);

        for (int i = 0; i < 8; i++)
            hold(~(8'd1 << i), {(i == 6) ? 1'b0 : 1'b1, LUT[(13+i) % 16]}, 5);
        hold(8'hFF, 8'hFF, 4);

        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
